grayscale_frame_writer: RTL



---
 rtl/grayscale_frame_writer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/grayscale_frame_writer.sv
// rtl/grayscale_frame_writer.sv - RGB FIFO to grayscale BRAM frame writer, one pixel per clock
// Modes: 0=average, 1/3=luma, 2=luma threshold; mode/threshold held for a whole frame.
module grayscale_frame_writer #(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = $clog2(BASE_ADDR + WIDTH * HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [7:0]        threshold,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [23:0]       in_dout,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [7:0]        out_wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0]     X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          thr_q, thr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pop;

  logic [9:0]  sum_rgb;
  logic [15:0] luma_acc;
  logic [7:0]  avg_px, luma_px, bin_px, conv_px;

  always_comb begin
    sum_rgb  = {2'b00, in_dout[23:16]} + {2'b00, in_dout[15:8]} + {2'b00, in_dout[7:0]};
    avg_px   = 8'(sum_rgb / 10'd3);
    luma_acc = 16'd77  * {8'h00, in_dout[23:16]}
             + 16'd150 * {8'h00, in_dout[15:8]}
             + 16'd29  * {8'h00, in_dout[7:0]};
    luma_px  = 8'(luma_acc >> 8);
    bin_px   = (luma_px >= thr_q) ? 8'hFF : 8'h00;
    case (mode_q)
      2'd0:    conv_px = avg_px;
      2'd2:    conv_px = bin_px;
      default: conv_px = luma_px;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    mode_d     = mode_q;
    thr_d      = thr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_empty) begin
          mode_d     = mode;
          thr_d      = threshold;
          x_d        = '0;
          y_d        = '0;
          row_base_d = BASE;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        pop = !in_empty;
        if (pop) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base_q + ADDR_W'(x_q);
          wr_data_d = conv_px;
          if (x_q == X_LAST) begin
            x_d        = '0;
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + ROW_STEP;
            if (y_q == Y_LAST) state_d = FLUSH;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // First FLUSH cycle carries the final write; the second pulses frame_done.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= BASE;
      mode_q     <= 2'd0;
      thr_q      <= 8'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Reset suppresses both the pending write and any pop in the same cycle.
  assign in_rd_en    = pop && !reset;
  assign out_wr_en   = wr_en_q && !reset;
  assign out_wr_addr = wr_addr_q;
  assign out_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule
